// File: rtl/graphics_pkg.sv
// Shared graphics definitions: screen geometry, command opcodes and common types
// used by the drawing engines that sit on the SPI command stream.
package graphics_pkg;

  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 400;

  localparam logic [7:0] OPC_SET_PIXEL    = 8'h10;
  localparam logic [7:0] OPC_FILL_RECT    = 8'h12;
  localparam logic [7:0] OPC_DRAW_LINE    = 8'h17;
  localparam logic [7:0] OPC_SWAP_BUFFERS = 8'h19;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    SETUP   = 2'd2,
    FILL    = 2'd3
  } fill_state_t;

  typedef logic [17:0] pixel_address_t;
  typedef logic [3:0]  colour_index_t;

endpackage

// File: rtl/fill_rect_engine_raster_walker.sv
// Walks a clipped rectangle row by row, producing one frame buffer address per
// advance and flagging the final pixel. Row stride is fixed at 640 pixels.
module raster_walker
  import graphics_pkg::*;
(
  input  logic           clock_in,
  input  logic           reset_in,
  input  logic           start,
  input  logic [9:0]     x,
  input  logic [10:0]    x_end,
  input  logic [8:0]     y,
  input  logic [10:0]    y_end,
  input  logic           advance,
  output pixel_address_t address,
  output logic           last
);

  localparam pixel_address_t ROW_STRIDE = 18'd640;

  logic [9:0]     x_start_r;
  logic [10:0]    x_end_r;
  logic [10:0]    y_end_r;
  logic [9:0]     column_r;
  logic [8:0]     row_r;
  pixel_address_t row_base_r;
  pixel_address_t address_r;
  pixel_address_t y_base_s;
  logic           row_end_s;

  // y*640 built from shifts; end-of-row and end-of-rectangle detection
  always_comb begin
    y_base_s  = ({9'd0, y} << 9) + ({9'd0, y} << 7);
    row_end_s = ({1'b0, column_r} == (x_end_r - 11'd1));
    last      = row_end_s && ({2'b00, row_r} == (y_end_r - 11'd1));
  end

  // Counters and address register; the address is kept registered so the
  // write port sees a glitch-free value that is held while advance is low
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      x_start_r  <= 10'd0;
      x_end_r    <= 11'd0;
      y_end_r    <= 11'd0;
      column_r   <= 10'd0;
      row_r      <= 9'd0;
      row_base_r <= 18'd0;
      address_r  <= 18'd0;
    end else if (start) begin
      x_start_r  <= x;
      x_end_r    <= x_end;
      y_end_r    <= y_end;
      column_r   <= x;
      row_r      <= y;
      row_base_r <= y_base_s;
      address_r  <= y_base_s + {8'd0, x};
    end else if (advance) begin
      if (row_end_s) begin
        column_r   <= x_start_r;
        row_r      <= row_r + 9'd1;
        row_base_r <= row_base_r + ROW_STRIDE;
        address_r  <= row_base_r + ROW_STRIDE + {8'd0, x_start_r};
      end else begin
        column_r  <= column_r + 10'd1;
        address_r <= address_r + 18'd1;
      end
    end
  end

  assign address = address_r;

endmodule

// File: rtl/fill_rect_engine.sv
// Fill-rect command decoder: captures operands from the SPI command stream,
// clips the rectangle to the screen and streams pixel writes to the frame buffer.
module fill_rect_engine
  import graphics_pkg::*;
#(
  parameter int         SCREEN_WIDTH     = graphics_pkg::SCREEN_WIDTH,
  parameter int         SCREEN_HEIGHT    = graphics_pkg::SCREEN_HEIGHT,
  parameter logic [7:0] OPCODE_FILL_RECT = graphics_pkg::OPC_FILL_RECT
) (
  input  logic           clock_in,
  input  logic           reset_in,
  input  logic [7:0]     op_code_in,
  input  logic           op_code_valid_in,
  input  logic [7:0]     operand_in,
  input  logic           operand_valid_in,
  input  logic [31:0]    operand_count_in,
  output pixel_address_t pixel_write_address_out,
  output colour_index_t  pixel_write_data_out,
  output logic           pixel_write_valid_out,
  input  logic           pixel_write_ready_in,
  output logic           busy_out,
  output logic           command_dropped_out
);

  localparam logic [10:0] WIDTH_L  = 11'(SCREEN_WIDTH);
  localparam logic [10:0] HEIGHT_L = 11'(SCREEN_HEIGHT);

  fill_state_t   state_r;
  logic [9:0]    x_r;
  logic [8:0]    y_r;
  logic [9:0]    w_r;
  logic [8:0]    h_r;
  colour_index_t colour_r;
  colour_index_t data_r;
  logic          valid_r;
  logic          busy_r;
  logic          dropped_r;
  logic          match_prev_r;
  logic          ignore_r;

  logic          match_s;
  logic          rising_s;
  logic          busy_state_s;
  logic          capture_s;
  logic [10:0]   x_sum_s;
  logic [10:0]   y_sum_s;
  logic [10:0]   x_end_s;
  logic [10:0]   y_end_s;
  logic          reject_s;
  logic          start_s;
  logic          advance_s;
  logic          last_s;

  // Command decode, clipping and walker control
  always_comb begin
    match_s      = op_code_valid_in && (op_code_in == OPCODE_FILL_RECT);
    rising_s     = match_s && !match_prev_r;
    busy_state_s = (state_r == SETUP) || (state_r == FILL);
    capture_s    = match_s && !ignore_r && operand_valid_in && !busy_state_s;
    x_sum_s      = {1'b0, x_r} + {1'b0, w_r};
    y_sum_s      = {2'b00, y_r} + {2'b00, h_r};
    if (x_sum_s > WIDTH_L) begin
      x_end_s = WIDTH_L;
    end else begin
      x_end_s = x_sum_s;
    end
    if (y_sum_s > HEIGHT_L) begin
      y_end_s = HEIGHT_L;
    end else begin
      y_end_s = y_sum_s;
    end
    reject_s  = (w_r == 10'd0) || (h_r == 9'd0) ||
                ({1'b0, x_r} >= WIDTH_L) || ({2'b00, y_r} >= HEIGHT_L);
    start_s   = (state_r == SETUP) && !reject_s;
    advance_s = valid_r && pixel_write_ready_in;
  end

  raster_walker u_walker (
    .clock_in (clock_in),
    .reset_in (reset_in),
    .start    (start_s),
    .x        (x_r),
    .x_end    (x_end_s),
    .y        (y_r),
    .y_end    (y_end_s),
    .advance  (advance_s),
    .address  (pixel_write_address_out),
    .last     (last_s)
  );

  // Control FSM with operand capture and registered handshake/status outputs
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_r      <= IDLE;
      x_r          <= 10'd0;
      y_r          <= 9'd0;
      w_r          <= 10'd0;
      h_r          <= 9'd0;
      colour_r     <= 4'd0;
      data_r       <= 4'd0;
      valid_r      <= 1'b0;
      busy_r       <= 1'b0;
      dropped_r    <= 1'b0;
      match_prev_r <= 1'b0;
      ignore_r     <= 1'b0;
    end else begin
      match_prev_r <= match_s;
      dropped_r    <= 1'b0;
      if (!match_s) begin
        ignore_r <= 1'b0;
      end
      if (capture_s) begin
        case (operand_count_in)
          32'd1:   x_r[9:8] <= operand_in[1:0];
          32'd2:   x_r[7:0] <= operand_in;
          32'd3:   y_r[8]   <= operand_in[0];
          32'd4:   y_r[7:0] <= operand_in;
          32'd5:   w_r[9:8] <= operand_in[1:0];
          32'd6:   w_r[7:0] <= operand_in;
          32'd7:   h_r[8]   <= operand_in[0];
          32'd8:   h_r[7:0] <= operand_in;
          // The last operand consumes the command: stay deaf until the opcode drops
          32'd9: begin
            colour_r <= operand_in[3:0];
            ignore_r <= 1'b1;
          end
          default: begin
          end
        endcase
      end
      case (state_r)
        IDLE: begin
          if (match_s && !ignore_r) begin
            state_r <= COLLECT;
          end else begin
            state_r <= IDLE;
          end
        end
        COLLECT: begin
          if (!match_s) begin
            state_r <= IDLE;
          end else if (operand_valid_in && (operand_count_in == 32'd9)) begin
            state_r <= SETUP;
            busy_r  <= 1'b1;
          end else begin
            state_r <= COLLECT;
          end
        end
        SETUP: begin
          if (reject_s) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            state_r <= FILL;
            valid_r <= 1'b1;
            data_r  <= colour_r;
          end
        end
        FILL: begin
          if (advance_s && last_s) begin
            state_r <= IDLE;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
          end else begin
            state_r <= FILL;
          end
        end
        default: begin
          state_r <= IDLE;
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
      if (busy_state_s && rising_s) begin
        dropped_r <= 1'b1;
        ignore_r  <= 1'b1;
      end
    end
  end

  assign pixel_write_data_out  = data_r;
  assign pixel_write_valid_out = valid_r;
  assign busy_out              = busy_r;
  assign command_dropped_out   = dropped_r;

endmodule

// File: tb/tb_fill_rect_engine.sv
// Self-checking bench for fill_rect_engine: directed corner cases plus random
// rectangles compared against a clip-and-scan reference model.
module tb_fill_rect_engine;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  op_code = 8'h00;
  logic        op_code_valid = 1'b0;
  logic [7:0]  operand = 8'h00;
  logic        operand_valid = 1'b0;
  logic [31:0] operand_count = 32'd0;
  logic [17:0] pw_addr;
  logic [3:0]  pw_data;
  logic        pw_valid;
  logic        pw_ready = 1'b1;
  logic        busy;
  logic        dropped;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_cnt = 0;
  int drop_cnt = 0;
  int ready_mode = 0;
  int pat_idx = 0;
  logic [3:0] ready_pat = 4'b1001;

  logic [7:0] ops_buf [1:9];
  int exp_q[$];
  int got_addr[$];
  int got_data[$];

  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic        prev_reset = 1'b1;
  logic [17:0] prev_addr = 18'd0;
  logic [3:0]  prev_data = 4'd0;

  fill_rect_engine dut (
    .clock_in                (clock),
    .reset_in                (reset),
    .op_code_in              (op_code),
    .op_code_valid_in        (op_code_valid),
    .operand_in              (operand),
    .operand_valid_in        (operand_valid),
    .operand_count_in        (operand_count),
    .pixel_write_address_out (pw_addr),
    .pixel_write_data_out    (pw_data),
    .pixel_write_valid_out   (pw_valid),
    .pixel_write_ready_in    (pw_ready),
    .busy_out                (busy),
    .command_dropped_out     (dropped)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Ready driver: always high, random, or the repeating 1-0-0-1 pattern
  initial begin
    forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
        0: pw_ready = 1'b1;
        1: pw_ready = 1'($urandom_range(0, 1));
        2: begin
          pw_ready = ready_pat[pat_idx];
          pat_idx  = (pat_idx + 1) % 4;
        end
        default: pw_ready = 1'b1;
      endcase
    end
  end

  // Monitor: records handshakes, counts busy/drop cycles, checks hold-while-stalled
  initial begin
    forever begin
      @(negedge clock);
      if (busy) busy_cnt++;
      if (dropped) drop_cnt++;
      if (prev_valid && !prev_ready && !prev_reset) begin
        check("hold_valid", int'(pw_valid), 1);
        check("hold_addr", int'(pw_addr), int'(prev_addr));
        check("hold_data", int'(pw_data), int'(prev_data));
      end
      if (pw_valid && pw_ready && !reset) begin
        got_addr.push_back(int'(pw_addr));
        got_data.push_back(int'(pw_data));
      end
      prev_valid = pw_valid;
      prev_ready = pw_ready;
      prev_reset = reset;
      prev_addr  = pw_addr;
      prev_data  = pw_data;
    end
  end

  // Reference model: clip to the screen, then scan rows top to bottom
  task automatic set_expect(input int x, input int y, input int w, input int h);
    int xe;
    int ye;
    xe = (x + w > 640) ? 640 : x + w;
    ye = (y + h > 400) ? 400 : y + h;
    exp_q.delete();
    for (int yy = y; yy < ye; yy++)
      for (int xx = x; xx < xe; xx++)
        exp_q.push_back(yy * 640 + xx);
    got_addr.delete();
    got_data.delete();
    busy_cnt = 0;
    drop_cnt = 0;
  endtask

  task automatic build_ops(input int x, input int y, input int w, input int h, input int c);
    logic [9:0]  xv;
    logic [8:0]  yv;
    logic [9:0]  wv;
    logic [8:0]  hv;
    logic [3:0]  cv;
    logic [31:0] r;
    xv = 10'(x); yv = 9'(y); wv = 10'(w); hv = 9'(h); cv = 4'(c);
    r = $urandom;
    ops_buf[1] = {r[7:2], xv[9:8]};
    ops_buf[2] = xv[7:0];
    ops_buf[3] = {r[15:9], yv[8]};
    ops_buf[4] = yv[7:0];
    ops_buf[5] = {r[23:18], wv[9:8]};
    ops_buf[6] = wv[7:0];
    ops_buf[7] = {r[30:24], hv[8]};
    ops_buf[8] = hv[7:0];
    r = $urandom;
    ops_buf[9] = {r[3:0], cv};
  endtask

  task automatic send_cmd(input logic [7:0] opc, input int n_ops);
    tick();
    op_code = opc;
    op_code_valid = 1'b1;
    for (int i = 1; i <= n_ops; i++) begin
      operand = ops_buf[i];
      operand_count = 32'(i);
      operand_valid = 1'b1;
      tick();
    end
    operand_valid = 1'b0;
    op_code_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      @(negedge clock);
      if (!busy && !pw_valid) done = 1'b1;
    end
    check("idle_timeout", int'(done), 1);
  endtask

  task automatic compare_writes(input int c);
    int n;
    check("write_count", got_addr.size(), exp_q.size());
    n = (got_addr.size() < exp_q.size()) ? got_addr.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check("write_addr", got_addr[i], exp_q[i]);
      check("write_data", got_data[i], c);
    end
  endtask

  task automatic run_rect(input int x, input int y, input int w, input int h, input int c);
    set_expect(x, y, w, h);
    build_ops(x, y, w, h, c);
    send_cmd(8'h12, 9);
    @(negedge clock);
    check("setup_busy", int'(busy), 1);
    check("setup_valid", int'(pw_valid), 0);
    @(negedge clock);
    check("first_valid", int'(pw_valid), (exp_q.size() > 0) ? 1 : 0);
    wait_idle(3000);
    compare_writes(c);
    if (exp_q.size() == 0)
      check("reject_busy_cycles", busy_cnt, 1);
    else if (ready_mode == 0)
      check("busy_cycles", busy_cnt, exp_q.size() + 1);
    check("no_drop", drop_cnt, 0);
  endtask

  initial begin
    // Reset state
    tick(); tick(); tick();
    @(negedge clock);
    check("rst_valid", int'(pw_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_addr", int'(pw_addr), 0);
    check("rst_data", int'(pw_data), 0);
    check("rst_drop", int'(dropped), 0);
    tick();
    reset = 1'b0;

    ready_mode = 0;
    run_rect(10, 20, 3, 2, 5);
    run_rect(638, 399, 10, 10, 9);
    run_rect(100, 100, 0, 5, 1);
    run_rect(700, 10, 5, 5, 2);
    run_rect(5, 450, 5, 5, 2);

    ready_mode = 2;
    pat_idx = 0;
    run_rect(5, 5, 2, 2, 12);

    // Second fill while busy: one drop pulse, first rect untouched
    ready_mode = 0;
    set_expect(100, 50, 3, 1);
    build_ops(100, 50, 3, 1, 7);
    send_cmd(8'h12, 9);
    build_ops(0, 0, 20, 20, 4);
    send_cmd(8'h12, 9);
    wait_idle(200);
    repeat (4) tick();
    compare_writes(7);
    check("drop_pulses", drop_cnt, 1);

    // Aborted command and a foreign opcode: no activity at all
    set_expect(0, 0, 0, 0);
    build_ops(1, 1, 4, 4, 6);
    send_cmd(8'h12, 5);
    build_ops(1, 1, 4, 4, 6);
    send_cmd(8'h10, 9);
    repeat (6) tick();
    check("abort_writes", got_addr.size(), 0);
    check("abort_busy", busy_cnt, 0);
    check("abort_drop", drop_cnt, 0);

    // Reset in the middle of a fill
    set_expect(0, 0, 10, 10);
    build_ops(0, 0, 10, 10, 2);
    send_cmd(8'h12, 9);
    for (int k = 0; k < 200 && got_addr.size() < 5; k++) @(negedge clock);
    check("pre_reset_writes", int'(got_addr.size() >= 5), 1);
    tick();
    reset = 1'b1;
    tick();
    @(negedge clock);
    check("midrst_valid", int'(pw_valid), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_addr", int'(pw_addr), 0);
    tick();
    reset = 1'b0;
    run_rect(0, 0, 1, 1, 3);

    // Random rectangles, with garbage in the unused operand bits
    for (int i = 0; i < 14; i++) begin
      int x;
      int y;
      ready_mode = i % 3;
      x = (i % 4 == 0) ? int'($urandom_range(600, 700)) : int'($urandom_range(0, 1023));
      y = (i % 4 == 1) ? int'($urandom_range(385, 420)) : int'($urandom_range(0, 511));
      run_rect(x, y, int'($urandom_range(0, 24)), int'($urandom_range(0, 10)),
               int'($urandom_range(0, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
